inst_mem_responder: RTL and testbench
=====================================

Name: inst_mem_responder

Overview:
- Instruction-memory responder for the fetch stage: accepts word-fetch requests (address + strobe) and returns the instruction word after a fixed latency.
- Pipelined and backpressured; supports a flush from jump/exception redirect that discards in-flight fetches.
- Includes a preload write port so benches and boot logic can fill the array.
- Sits between the fetch stage's inst_addr/next_fetch side and its inst input.

Parameters:
- ADDR_W, 8, word-index width; array holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- req_valid  in  1  fetch request strobe.
- req_addr  in  32  byte address of the instruction.
- req_ready  out  1  request accepted at this edge when req_valid && req_ready.
- flush  in  1  redirect (jump/exception); kill all in-flight fetches.
- resp_valid  out  1  response present.
- resp_inst  out  32  instruction word.
- resp_addr  out  32  address of the returned word (echo of req_addr).
- resp_err  out  1  misaligned (req_addr[1:0]!=0) or out-of-range address.
- resp_ready  in  1  consumer accepts the response this edge.
- ld_en  in  1  preload write enable.
- ld_addr  in  ADDR_W  preload word index.
- ld_data  in  32  preload word.

Behaviour:
- Reset (resetn=0 at edge):
  - All stage valids are cleared; resp_valid=0, resp_inst=0, resp_addr=0, resp_err=0.
  - Array contents are NOT cleared.
  - req_ready=0 while resetn=0.
- Pipeline structure:
  - LATENCY stages, each holding {valid, addr, inst, err}. Stage 1 is loaded at the accepting edge; the last stage drives the resp_* outputs.
- Advance condition:
  - advance = !(resp_valid && !resp_ready).
  - When advance=1, every stage shifts one step. A bubble enters stage 1 when no request is accepted.
- Request acceptance:
  - req_ready = resetn && advance && !flush.
  - A request accepted at edge k produces resp_valid=1 in the cycle after edge k+LATENCY-1, provided advance stays 1. Each stall cycle adds one cycle.
  - Back-to-back accepts give one response per cycle.
- Array read:
  - The array is read with word index (req_addr-BASE_ADDR)>>2, sampled at the accepting edge.
  - If ld_en writes the same index at that edge, the read returns the OLD word.
- Error response:
  - resp_err=1 if req_addr[1:0]!=0, req_addr<BASE_ADDR, or the index is >= 2^ADDR_W.
  - On error, resp_inst=32'h0000_0000 (NOP). The error response still occupies a slot and is delivered in order.
- Flush:
  - At an edge with flush=1, all stage valids clear, including the output stage even if it is stalled.
  - No request is accepted at that edge, and resp_valid=0 in the next cycle.
  - flush overrides resp_ready.
- Stall behaviour:
  - While resp_valid && !resp_ready, all resp_* outputs hold stable and req_ready=0.
- Preload port:
  - ld_en writes the array at each edge, independent of request traffic, stall, or flush.
- Ordering:
  - Responses are strictly in request order; no reordering and no duplication.
- Reset mid-operation:
  - In-flight fetches are dropped exactly as with flush.

Test Plan:
1. Preload words 0..3 = 32'h11111111, 22222222, 33333333, 44444444; LATENCY=2; issue req_addr 0,4,8,12 on consecutive edges with resp_ready=1 → resp_valid rises 2 cycles after the first accept, then resp_inst = 11111111, 22222222, 33333333, 44444444 on 4 consecutive cycles with matching resp_addr, resp_err=0.
2. Same stream with resp_ready=0 for 3 cycles after the first response → req_ready=0 and resp_inst holds 32'h11111111 for 3 cycles; the remaining words then follow in order with none lost or duplicated.
3. Issue 0,4,8, then assert flush one cycle after the third accept → resp_valid=0 the cycle after the flush edge; no responses for 4 or 8 appear; a new request to 12 returns 44444444 after LATENCY cycles.
4. req_addr=32'h0000_0002, then req_addr=(2^ADDR_W)*4 → two responses, each with resp_err=1 and resp_inst=0, in order.
5. ld_en writing index 1 = 32'hDEADBEEF at the same edge as accepting req_addr=4 → response is 22222222; a following request to 4 returns DEADBEEF.
6. resetn=0 for one edge with 2 fetches in flight → resp_valid=0 and outputs all zero; no stale responses after reset; preloaded words survive.

Source files
------------

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - fixed-latency instruction memory responder with flush and preload
// Fetch requests walk a LATENCY-deep pipeline; the last stage drives resp_* and stalls the whole pipe.
module inst_mem_responder #(
  parameter int          ADDR_W    = 8,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [31:0]       resp_inst,
  output logic [31:0]       resp_addr,
  output logic              resp_err,
  input  logic              resp_ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]        r_mem [DEPTH];
  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_addr [LATENCY];
  logic [31:0]        r_inst [LATENCY];

  logic              w_advance;
  logic              w_accept;
  logic              w_err;
  logic [31:0]       w_off;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_idx;

  assign w_advance = !(r_valid[LATENCY-1] && !resp_ready);
  assign req_ready = resetn && w_advance && !flush;
  assign w_accept  = req_valid && req_ready;

  assign w_off  = req_addr - BASE_ADDR;
  assign w_word = w_off >> 2;
  assign w_idx  = w_word[ADDR_W-1:0];
  assign w_err  = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                  ((w_word >> ADDR_W) != 32'd0);

  // Preload writes are independent of reset, stall and flush.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  // A same-edge preload write is not visible to this read, so the old word is returned.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_addr[i] <= '0;
        r_inst[i] <= '0;
      end
    end else if (w_advance) begin
      r_valid[0] <= w_accept;
      r_err[0]   <= w_accept && w_err;
      r_addr[0]  <= w_accept ? req_addr : 32'd0;
      r_inst[0]  <= (w_accept && !w_err) ? r_mem[w_idx] : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
        r_addr[i]  <= r_addr[i-1];
        r_inst[i]  <= r_inst[i-1];
      end
    end
  end

  assign resp_valid = r_valid[LATENCY-1];
  assign resp_err   = r_err[LATENCY-1];
  assign resp_addr  = r_addr[LATENCY-1];
  assign resp_inst  = r_inst[LATENCY-1];

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - self-checking bench for inst_mem_responder
// A queue-based reference model tracks every fetch; directed sequences check exact delivered words.
module tb_inst_mem_responder;

  localparam int          ADDR_W  = 8;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam logic [31:0] DEPTH   = 32'd1 << ADDR_W;

  logic              clk;
  logic              resetn;
  logic              req_valid;
  logic [31:0]       req_addr;
  logic              req_ready;
  logic              flush;
  logic              resp_valid;
  logic [31:0]       resp_inst;
  logic [31:0]       resp_addr;
  logic              resp_err;
  logic              resp_ready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  inst_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .flush(flush), .resp_valid(resp_valid), .resp_inst(resp_inst),
    .resp_addr(resp_addr), .resp_err(resp_err), .resp_ready(resp_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
    int          rem;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] inst;
  } vec_t;

  ent_t        q[$];
  logic [31:0] mmem [DEPTH];
  logic [31:0] got_inst[$];
  logic        got_err[$];
  logic [31:0] exp_inst[$];
  logic        exp_err[$];
  vec_t        vt [6];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Remaining advancing edges before the fetch reaches the output
  function automatic ent_t model_fetch(input logic [31:0] a);
    ent_t        e;
    logic [31:0] w;
    w      = (a - BASE) / 4;
    e.addr = a;
    e.rem  = LATENCY - 1;
    e.err  = (a % 4 != 0) || (a < BASE) || (w >= DEPTH);
    e.inst = e.err ? 32'h0 : mmem[w[ADDR_W-1:0]];
    return e;
  endfunction

  task automatic tick();
    logic vis;
    logic exp_ready;
    #1;
    vis       = (q.size() > 0) && (q[0].rem == 0);
    exp_ready = resetn && !flush && !(vis && !resp_ready);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("resp_valid", 32'(resp_valid), 32'(vis));
    if (vis) begin
      check("resp_addr", resp_addr, q[0].addr);
      check("resp_inst", resp_inst, q[0].inst);
      check("resp_err", 32'(resp_err), 32'(q[0].err));
    end
    if (resetn && !flush && resp_valid && resp_ready) begin
      got_inst.push_back(resp_inst);
      got_err.push_back(resp_err);
    end
    if (!resetn || flush) begin
      q.delete();
    end else if (!(vis && !resp_ready)) begin
      if (vis) void'(q.pop_front());
      foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
      if (req_valid) q.push_back(model_fetch(req_addr));
    end
    if (ld_en) mmem[ld_addr] = ld_data;
    @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input string name);
    check({name, "_count"}, 32'(got_inst.size()), 32'(exp_inst.size()));
    for (int i = 0; i < got_inst.size() && i < exp_inst.size(); i++) begin
      check({name, "_inst"}, got_inst[i], exp_inst[i]);
      check({name, "_err"}, 32'(got_err[i]), 32'(exp_err[i]));
    end
    got_inst.delete(); got_err.delete(); exp_inst.delete(); exp_err.delete();
  endtask

  task automatic expect_word(input logic [31:0] inst, input logic err);
    exp_inst.push_back(inst);
    exp_err.push_back(err);
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0;
    resp_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_inst", resp_inst, 32'h0);
    check("rst_addr", resp_addr, 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) begin
      ld_en = 1'b1;
      ld_addr = ADDR_W'(i);
      ld_data = (i < 4) ? 32'h11111111 * 32'(i + 1) : (32'hC0DE0000 | 32'(i));
      tick();
    end
    ld_en = 1'b0;

    // Back-to-back stream, first response two cycles after the first accept
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4);
      tick();
      if (i == 0) check("t1_lat0", 32'(resp_valid), 32'h0);
      if (i == 1) begin
        check("t1_lat1", 32'(resp_valid), 32'h1);
        check("t1_first", resp_inst, 32'h11111111);
      end
    end
    req_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) expect_word(32'h11111111 * 32'(i + 1), 1'b0);
    check_seq("t1");

    // Consumer stalls for three edges on the first response
    req_valid = 1'b1; req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    resp_ready = 1'b0; req_addr = 32'h8;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_hold_valid", 32'(resp_valid), 32'h1);
      check("t2_hold_inst", resp_inst, 32'h11111111);
      check("t2_hold_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1; tick();
    req_addr = 32'hC; tick();
    req_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) expect_word(32'h11111111 * 32'(i + 1), 1'b0);
    check_seq("t2");

    // Flush one cycle after the third accept
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'(i * 4); tick();
    end
    req_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    check("t3_flush_valid", 32'(resp_valid), 32'h0);
    req_valid = 1'b1; req_addr = 32'hC; tick();
    req_valid = 1'b0;
    check("t3_new_lat0", 32'(resp_valid), 32'h0);
    tick();
    check("t3_new_valid", 32'(resp_valid), 32'h1);
    check("t3_new_inst", resp_inst, 32'h44444444);
    repeat (3) tick();
    expect_word(32'h11111111, 1'b0);
    expect_word(32'h44444444, 1'b0);
    check_seq("t3");

    // Error and boundary addresses, delivered in order
    vt[0] = '{addr: 32'h0000_0002, err: 1'b1, inst: 32'h0};
    vt[1] = '{addr: DEPTH * 4,     err: 1'b1, inst: 32'h0};
    vt[2] = '{addr: DEPTH * 4 - 4, err: 1'b0, inst: 32'hC0DE00FF};
    vt[3] = '{addr: 32'h0000_0001, err: 1'b1, inst: 32'h0};
    vt[4] = '{addr: 32'h0000_0008, err: 1'b0, inst: 32'h33333333};
    vt[5] = '{addr: 32'hFFFF_FFFC, err: 1'b1, inst: 32'h0};
    foreach (vt[i]) begin
      req_valid = 1'b1; req_addr = vt[i].addr; tick();
      expect_word(vt[i].inst, vt[i].err);
    end
    req_valid = 1'b0;
    repeat (4) tick();
    check_seq("t4");

    // Preload write racing a read of the same word
    req_valid = 1'b1; req_addr = 32'h4;
    ld_en = 1'b1; ld_addr = ADDR_W'(1); ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    expect_word(32'h22222222, 1'b0);
    expect_word(32'hDEADBEEF, 1'b0);
    check_seq("t5");

    // Reset with two fetches in flight
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_valid = 1'b0; resetn = 1'b0; tick();
    check("t6_valid", 32'(resp_valid), 32'h0);
    check("t6_inst", resp_inst, 32'h0);
    check("t6_addr", resp_addr, 32'h0);
    check("t6_err", 32'(resp_err), 32'h0);
    check("t6_ready", 32'(req_ready), 32'h0);
    resetn = 1'b1; resp_ready = 1'b1;
    repeat (3) tick();
    req_valid = 1'b1; req_addr = 32'h8; tick();
    req_addr = 32'h4; tick();
    req_valid = 1'b0;
    repeat (4) tick();
    expect_word(32'h33333333, 1'b0);
    expect_word(32'hDEADBEEF, 1'b0);
    check_seq("t6");

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      int r;
      resetn     = ($urandom_range(0, 99) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      req_valid  = ($urandom_range(0, 2) != 0);
      r = int'($urandom_range(0, 9));
      req_addr = 32'($urandom_range(0, 255)) * 4;
      if (r == 0) req_addr = $urandom;
      if (r == 1) req_addr = req_addr | 32'h2;
      if (r == 2) req_addr = req_addr + DEPTH * 4;
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = ADDR_W'($urandom_range(0, 255));
      ld_data = $urandom;
      tick();
    end
    resetn = 1'b1; flush = 1'b0; req_valid = 1'b0; ld_en = 1'b0; resp_ready = 1'b1;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
